// File: rtl/lsu_ecc_wb_ctl_pkg.sv
// Shared types for the DCCM single-bit-error scrub writeback controller.
// Latency: n/a (types, constants and a small address helper only).
// Backpressure: n/a.
package lsu_ecc_wb_ctl_pkg;

  localparam int DCCM_BITS  = 16;
  localparam int DATA_WIDTH = 32;
  localparam int ECC_WIDTH  = 7;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W   = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } ecc_wb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DCCM_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } ecc_wb_entry_t;

  // Byte address -> word-aligned byte address (bank word is 4 bytes).
  function automatic logic [DCCM_BITS-1:0] word_addr(input logic [DCCM_BITS-1:0] a);
    return {a[DCCM_BITS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_ecc_wb_ctl_if.sv
// Bus bundle between the LSU dc3 ECC check, the store buffer and the DCCM write port.
// Latency: n/a (wires only).
// Backpressure: stbuf_wr_req/stbuf_wr_gnt is a per-cycle request/grant pair.
// Ports: dc3 error report (valid/err flags/addresses/corrected data/flush),
//        store-buffer request/address/grant, scrub write enable/address/data/ecc,
//        busy and drop status. slave = controller side, master = environment side.
interface lsu_ecc_wb_ctl_if;
  import lsu_ecc_wb_ctl_pkg::*;

  logic                  ecc_chk_valid_dc3;
  logic                  single_err_lo_dc3;
  logic                  single_err_hi_dc3;
  logic                  double_err_dc3;
  logic [DCCM_BITS-1:0]  addr_lo_dc3;
  logic [DCCM_BITS-1:0]  addr_hi_dc3;
  logic [DATA_WIDTH-1:0] sec_data_lo_dc3;
  logic [DATA_WIDTH-1:0] sec_data_hi_dc3;
  logic                  flush_dc3;

  logic                  stbuf_wr_req;
  logic [DCCM_BITS-1:0]  stbuf_wr_addr;
  logic                  stbuf_wr_gnt;

  logic                  dccm_scrub_wren;
  logic [DCCM_BITS-1:0]  dccm_scrub_addr;
  logic [DATA_WIDTH-1:0] dccm_scrub_data;
  logic [ECC_WIDTH-1:0]  dccm_scrub_ecc;

  logic                  ecc_wb_busy;
  logic                  ecc_wb_drop;

  modport slave (
    input  ecc_chk_valid_dc3, single_err_lo_dc3, single_err_hi_dc3, double_err_dc3,
           addr_lo_dc3, addr_hi_dc3, sec_data_lo_dc3, sec_data_hi_dc3, flush_dc3,
           stbuf_wr_req, stbuf_wr_addr,
    output stbuf_wr_gnt, dccm_scrub_wren, dccm_scrub_addr, dccm_scrub_data,
           dccm_scrub_ecc, ecc_wb_busy, ecc_wb_drop
  );

  modport master (
    output ecc_chk_valid_dc3, single_err_lo_dc3, single_err_hi_dc3, double_err_dc3,
           addr_lo_dc3, addr_hi_dc3, sec_data_lo_dc3, sec_data_hi_dc3, flush_dc3,
           stbuf_wr_req, stbuf_wr_addr,
    input  stbuf_wr_gnt, dccm_scrub_wren, dccm_scrub_addr, dccm_scrub_data,
           dccm_scrub_ecc, ecc_wb_busy, ecc_wb_drop
  );

endinterface

// File: rtl/lsu_ecc_wb_ctl_rvecc_encode.sv
// SECDED check-bit generator: Hamming bits over a 1-based codeword plus overall parity.
// Latency: combinational.
// Backpressure: none.
// Ports: din (data word) -> ecc (ECC_WIDTH-1 Hamming bits, MSB = overall parity).
module lsu_ecc_wb_ctl_rvecc_encode #(
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ECC_WIDTH-1:0]  ecc
);

  localparam int HAM_W = ECC_WIDTH - 1;
  localparam int CW    = DATA_WIDTH + HAM_W + 1;

  logic [DATA_WIDTH-1:0] sh;
  logic [HAM_W-1:0]      ham;

  // Data bits fill the non-power-of-two codeword positions in order; shifting
  // the word keeps the current data bit at sh[0]. Hamming bit k covers every
  // position whose index has bit k set.
  always_comb begin
    sh  = din;
    ham = '0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < HAM_W; k++) begin
          if (((p >> k) & 1) != 0) begin
            ham = ham ^ (HAM_W'(sh[0]) << k);
          end
        end
        sh = sh >> 1;
      end
    end
  end

  assign ecc = {^{din, ham}, ham};

endmodule

// File: rtl/lsu_ecc_wb_ctl.sv
// DCCM single-bit-error scrub controller: queues corrected dc3 words (2 entries) and
// writes them back through the DCCM write port shared with the store buffer.
// Latency: error at N -> entry valid and earliest scrub at N+1; ecc_wb_drop pulses at N+1.
// Backpressure: store buffer wins the port until STARVE_MAX consecutive denials, then one
// scrub is forced; a full queue discards new errors and reports them on ecc_wb_drop.
// Ports: clk, rst (sync, active-high), bus (lsu_ecc_wb_ctl_if.slave).
module lsu_ecc_wb_ctl
  import lsu_ecc_wb_ctl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  lsu_ecc_wb_ctl_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);

  ecc_wb_state_t         state_q, state_d;
  ecc_wb_entry_t         q0_q, q1_q, q0_d, q1_d;   // q0 = head (oldest)
  logic [STARVE_W-1:0]   cnt_q, cnt_d;
  logic                  drop_q, drop_d;

  logic                  qual_ok, qual_lo, qual_hi;
  logic                  scrub_wren, gnt;
  logic [DCCM_BITS-1:0]  stbuf_wa;
  logic [DATA_WIDTH-1:0] scrub_data;
  logic [ECC_WIDTH-1:0]  scrub_ecc;

  // A double error on either bank belongs to the trap path, so it blocks both banks.
  assign qual_ok = bus.ecc_chk_valid_dc3 & ~bus.flush_dc3 & ~bus.double_err_dc3;
  assign qual_lo = qual_ok & bus.single_err_lo_dc3;
  assign qual_hi = qual_ok & bus.single_err_hi_dc3;

  // Port ownership depends only on registered state and the store-buffer request.
  assign scrub_wren = q0_q.valid &
                      ((state_q == FORCE) | ((state_q == WAIT) & ~bus.stbuf_wr_req));
  assign gnt        = bus.stbuf_wr_req & ~scrub_wren;
  assign stbuf_wa   = word_addr(bus.stbuf_wr_addr);
  assign scrub_data = scrub_wren ? q0_q.data : '0;

  // Merge into a matching entry, else take a free slot, else flag a drop.
  function automatic void enq(input  logic                  vld,
                              input  logic [DCCM_BITS-1:0]  addr,
                              input  logic [DATA_WIDTH-1:0] data,
                              inout  ecc_wb_entry_t         e0,
                              inout  ecc_wb_entry_t         e1,
                              inout  logic                  dropped);
    logic [DCCM_BITS-1:0] wa;
    wa = word_addr(addr);
    if (vld) begin
      if (e0.valid && e0.addr == wa)      e0.data = data;
      else if (e1.valid && e1.addr == wa) e1.data = data;
      else if (!e0.valid)                 e0 = '{valid: 1'b1, addr: wa, data: data};
      else if (!e1.valid)                 e1 = '{valid: 1'b1, addr: wa, data: data};
      else                                dropped = 1'b1;
    end
  endfunction

  // Queue update order: pop, then stale kill, then lo and hi enqueue. Pop and kill are
  // exclusive because the port goes to only one writer per cycle.
  always_comb begin
    q0_d   = q0_q;
    q1_d   = q1_q;
    drop_d = 1'b0;
    if (scrub_wren) begin
      q0_d = q1_q;
      q1_d = '0;
    end else if (gnt) begin
      // The store-buffer word is newer than the corrected copy; scrubbing it would clobber it.
      if (q0_d.valid && q0_d.addr == stbuf_wa) begin
        q0_d = q1_d;
        q1_d = '0;
      end else if (q1_d.valid && q1_d.addr == stbuf_wa) begin
        q1_d = '0;
      end
    end
    enq(qual_lo, bus.addr_lo_dc3, bus.sec_data_lo_dc3, q0_d, q1_d, drop_d);
    enq(qual_hi, bus.addr_hi_dc3, bus.sec_data_hi_dc3, q0_d, q1_d, drop_d);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (q0_d.valid) state_d = WAIT;
      end
      WAIT: begin
        if (scrub_wren) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cnt_q == STARVE_LAST) state_d = FORCE;
        end
        if (!q0_d.valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      FORCE: begin
        cnt_d   = '0;
        state_d = q0_d.valid ? WAIT : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q0_q    <= '0;
      q1_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  lsu_ecc_wb_ctl_rvecc_encode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ECC_WIDTH  (ECC_WIDTH)
  ) u_ecc_enc (
    .din (scrub_data),
    .ecc (scrub_ecc)
  );

  assign bus.stbuf_wr_gnt    = gnt;
  assign bus.dccm_scrub_wren = scrub_wren;
  assign bus.dccm_scrub_addr = scrub_wren ? q0_q.addr : '0;
  assign bus.dccm_scrub_data = scrub_data;
  assign bus.dccm_scrub_ecc  = scrub_ecc;
  assign bus.ecc_wb_busy     = q0_q.valid;
  assign bus.ecc_wb_drop     = drop_q;

endmodule

// File: tb/tb_lsu_ecc_wb_ctl.sv
// Bench for lsu_ecc_wb_ctl: directed cycle table, reset-mid-operation sequence,
// then randomized traffic against a queue-based reference model.
module tb_lsu_ecc_wb_ctl;
  import lsu_ecc_wb_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ecc_wb_ctl_if bus();

  lsu_ecc_wb_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        chk, slo, shi, dbl, fl;
    logic [15:0] alo, ahi;
    logic [31:0] dlo, dhi;
    logic        req;
    logic [15:0] sa;
    logic        e_gnt, e_wren;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy, e_drop;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } ment_t;

  vec_t  vecs[$];
  ment_t mq[$];
  int    denied;
  bit    force_pend;
  bit    drop_pend;
  int    checks = 0;
  int    errors = 0;

  // Reference SECDED: data bit i sits at the i-th non-power-of-two codeword position.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    int pos[32];
    int n;
    logic [6:0] e;
    n = 0;
    e = '0;
    for (int c = 1; c < 39; c++) begin
      if ((c & (c - 1)) != 0) begin
        pos[n] = c;
        n++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) begin
        if ((((pos[i] >> k) & 1) != 0) && (((d >> i) & 32'd1) != 0))
          e = e ^ (7'd1 << k);
      end
    end
    e = e ^ {(^d) ^ (^e[5:0]), 6'd0};
    return e;
  endfunction

  function automatic void row(input logic chk, slo, shi, dbl, fl,
                              input logic [15:0] alo, input logic [31:0] dlo,
                              input logic [15:0] ahi, input logic [31:0] dhi,
                              input logic req, input logic [15:0] sa,
                              input logic e_gnt, e_wren, input logic [15:0] e_addr,
                              input logic [31:0] e_data, input logic e_busy, e_drop);
    vec_t v;
    v.chk = chk; v.slo = slo; v.shi = shi; v.dbl = dbl; v.fl = fl;
    v.alo = alo; v.dlo = dlo; v.ahi = ahi; v.dhi = dhi; v.req = req; v.sa = sa;
    v.e_gnt = e_gnt; v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data;
    v.e_busy = e_busy; v.e_drop = e_drop;
    vecs.push_back(v);
  endfunction

  function automatic vec_t idle_vec(input logic req);
    vec_t v;
    v = '{default: '0};
    v.req = req;
    v.sa  = 16'h0400;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ecc_chk_valid_dc3 = v.chk;
    bus.single_err_lo_dc3 = v.slo;
    bus.single_err_hi_dc3 = v.shi;
    bus.double_err_dc3    = v.dbl;
    bus.flush_dc3         = v.fl;
    bus.addr_lo_dc3       = v.alo;
    bus.addr_hi_dc3       = v.ahi;
    bus.sec_data_lo_dc3   = v.dlo;
    bus.sec_data_hi_dc3   = v.dhi;
    bus.stbuf_wr_req      = v.req;
    bus.stbuf_wr_addr     = v.sa;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic gnt, wren,
                            input logic [15:0] addr, input logic [31:0] data,
                            input logic busy, drop);
    check({tag, " gnt"},  64'(bus.stbuf_wr_gnt),    64'(gnt));
    check({tag, " wren"}, 64'(bus.dccm_scrub_wren), 64'(wren));
    check({tag, " addr"}, 64'(bus.dccm_scrub_addr), 64'(addr));
    check({tag, " data"}, 64'(bus.dccm_scrub_data), 64'(data));
    check({tag, " ecc"},  64'(bus.dccm_scrub_ecc),  64'(ref_ecc(data)));
    check({tag, " busy"}, 64'(bus.ecc_wb_busy),     64'(busy));
    check({tag, " drop"}, 64'(bus.ecc_wb_drop),     64'(drop));
  endtask

  // Reference model step: pop or count denial, stale kill, then lo/hi enqueue.
  task automatic model_step(input vec_t v, input logic r, input logic wren, input logic gnt);
    bit newdrop;
    bit ok;
    bit found;
    if (r) begin
      mq.delete();
      denied = 0; force_pend = 0; drop_pend = 0;
      return;
    end
    newdrop = 0;
    if (wren) begin
      void'(mq.pop_front());
      denied = 0; force_pend = 0;
    end else if (gnt && mq.size() > 0) begin
      denied++;
      if (denied >= STARVE_MAX) force_pend = 1;
    end
    if (gnt) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a[15:2] == v.sa[15:2]) begin
          mq.delete(i);
          break;
        end
      end
    end
    ok = v.chk && !v.fl && !v.dbl;
    for (int l = 0; l < 2; l++) begin
      logic [15:0] a;
      logic [31:0] d;
      bit e;
      e = (l == 0) ? v.slo : v.shi;
      a = (l == 0) ? v.alo : v.ahi;
      d = (l == 0) ? v.dlo : v.dhi;
      if (ok && e) begin
        found = 0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!found && mq[i].a[15:2] == a[15:2]) begin
            mq[i].d = d;
            found = 1;
          end
        end
        if (!found) begin
          if (mq.size() < 2) mq.push_back('{a: {a[15:2], 2'b00}, d: d});
          else newdrop = 1;
        end
      end
    end
    if (mq.size() == 0) begin
      denied = 0; force_pend = 0;
    end
    drop_pend = newdrop;
  endtask

  initial begin
    vec_t v;
    logic ew, eg;
    logic [15:0] ea;
    logic [31:0] ed;

    // chk slo shi dbl fl  alo dlo  ahi dhi  req sa  | gnt wren addr data busy drop
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,0,0);
    // single lo error
    row(1,1,0,0,0, 16'h0104,32'hDEADBEEF, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0104,32'hDEADBEEF,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // lo + hi same cycle
    row(1,1,1,0,0, 16'h0200,32'h11111111, 16'h0204,32'h22222222, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0200,32'h11111111,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0204,32'h22222222,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // starvation: 4 grants then forced scrub
    row(1,1,0,0,0, 16'h0302,32'h33333333, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 0,1,16'h0300,32'h33333333,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // full queue: drop pulse, then double error neither drops nor enqueues
    row(1,1,1,0,0, 16'h0500,32'hA5A5A5A5, 16'h0504,32'h5A5A5A5A, 1,16'h0400, 1,0,16'h0,32'h0,0,0);
    row(1,1,0,0,0, 16'h0300,32'h0BADF00D, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(1,1,0,1,0, 16'h0600,32'h66666666, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,1);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h0400, 0,1,16'h0500,32'hA5A5A5A5,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0504,32'h5A5A5A5A,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // stale kill by store-buffer write to same word
    row(1,1,0,0,0, 16'h0108,32'h01080108, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 1,16'h010A, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // flush suppresses enqueue
    row(1,1,0,0,1, 16'h0700,32'h77777777, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // full queue popping accepts one new error in the same cycle
    row(1,1,1,0,0, 16'h0800,32'h80808080, 16'h0804,32'h84848484, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(1,1,0,0,0, 16'h0808,32'h88888888, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0800,32'h80808080,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0804,32'h84848484,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0808,32'h88888888,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    // duplicate word overwrites pending data
    row(1,1,0,0,0, 16'h0900,32'h9A9A9A9A, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);
    row(1,1,0,0,0, 16'h0902,32'h9B9B9B9B, 16'h0,32'h0, 1,16'h0400, 1,0,16'h0,32'h0,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,1,16'h0900,32'h9B9B9B9B,1,0);
    row(0,0,0,0,0, 16'h0,32'h0, 16'h0,32'h0, 0,16'h0400, 0,0,16'h0,32'h0,0,0);

    // Reset state
    rst = 1'b1;
    drive(idle_vec(1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("row%0d", i), vecs[i].e_gnt, vecs[i].e_wren, vecs[i].e_addr,
                 vecs[i].e_data, vecs[i].e_busy, vecs[i].e_drop);
      @(posedge clk); #1;
    end

    // Reset with two entries pending and a would-be drop in the reset cycle
    v = idle_vec(1'b1);
    v.chk = 1; v.slo = 1; v.shi = 1;
    v.alo = 16'h0A00; v.dlo = 32'hAAAA0000; v.ahi = 16'h0A04; v.dhi = 32'hAAAA0004;
    drive(v);
    @(negedge clk);
    check_outs("rst_fill", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(idle_vec(1'b1));
    @(negedge clk);
    check_outs("rst_pend", 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    v = idle_vec(1'b1);
    v.chk = 1; v.slo = 1; v.alo = 16'h0B00; v.dlo = 32'hBBBBBBBB;
    drive(v);
    @(negedge clk);
    check_outs("rst_cyc", 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle_vec(1'b0));
    @(negedge clk);
    check_outs("rst_after", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_outs("rst_after2", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    mq.delete();
    denied = 0; force_pend = 0; drop_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      v = idle_vec(1'b0);
      v.chk = ($urandom_range(0, 99) < 40);
      v.slo = ($urandom_range(0, 99) < 50);
      v.shi = ($urandom_range(0, 99) < 35);
      v.dbl = ($urandom_range(0, 99) < 10);
      v.fl  = ($urandom_range(0, 99) < 10);
      v.alo = 16'h0100 + 16'($urandom_range(0, 15));
      v.ahi = 16'h0100 + 16'($urandom_range(0, 15));
      v.dlo = $urandom;
      v.dhi = $urandom;
      v.req = ($urandom_range(0, 99) < 55);
      v.sa  = 16'h0100 + 16'($urandom_range(0, 23));
      rst   = ($urandom_range(0, 199) == 0);
      drive(v);
      @(negedge clk);
      ew = (mq.size() != 0) && (force_pend || !v.req);
      eg = v.req && !ew;
      ea = ew ? mq[0].a : 16'h0;
      ed = ew ? mq[0].d : 32'h0;
      check_outs($sformatf("rnd%0d", c), eg, ew, ea, ed, (mq.size() != 0), drop_pend);
      model_step(v, rst, ew, eg);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
